// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding,
// instruction type codes, ALU operation codes and the decoded-field and
// control-bundle structures passed between the decoder and the FSM.
package mc_controller_pkg;

    // Binary state encoding, also driven onto the debug state port.
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_DP_EXEC  = 4'd2;
    localparam logic [3:0] ST_DP_WB    = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4;
    localparam logic [3:0] ST_MEM_RD   = 4'd5;
    localparam logic [3:0] ST_MEM_WB   = 4'd6;
    localparam logic [3:0] ST_MEM_WR   = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;

    typedef enum logic [1:0] {
        TYPE_DP  = 2'b00,
        TYPE_MEM = 2'b01,
        TYPE_BR  = 2'b10,
        TYPE_RSV = 2'b11
    } instr_type_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;
    localparam logic [2:0] ALU_MVN = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    typedef struct packed {
        instr_type_e itype;
        logic [2:0]  opcode;
        logic        cmp_only;
        logic        set_flags;
        logic        imm;
        logic        load;
        logic        link;
    } dec_t;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       pc_write;
        logic       ir_write;
        logic       regwrite;
        logic       ld_v;
        logic       ld_n;
        logic       ld_z;
        logic       ld_c;
        logic       i_or_d;
        logic       wd_sel;
        logic       mdr_sel;
        logic       op_sel;
        logic       op2_sel;
        logic       mux_sel;
        logic       pc_set;
        logic       data_sel;
        logic       rr_sel;
        logic       wr_sel;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    // A data-processing op updates the flags when S is set or when it is a
    // compare-only op (which has no other visible effect).
    function automatic logic writes_flags(input dec_t d);
        return d.set_flags | d.cmp_only;
    endfunction

    // Stores need the A/B register read path selecting the store-data
    // register throughout the instruction.
    function automatic logic is_store(input dec_t d);
        return (d.itype == TYPE_MEM) && !d.load;
    endfunction

endpackage

// File: rtl/mc_controller_instr_decode.sv
// Combinational field decode of the instruction register.
// Ports:
//   instr - IR contents from the datapath
//   dec   - decoded type and control fields
module mc_controller_instr_decode
    import mc_controller_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    // Register numbers, offsets and immediates are consumed by the datapath
    // directly; only the control fields are looked at here.
    logic unused_bits;
    assign unused_bits = ^{instr[31:30], instr[26], instr[19:0]};

    always_comb begin
        dec           = '0;
        dec.itype     = instr_type_e'(instr[29:28]);
        dec.opcode    = instr[23:21];
        dec.cmp_only  = instr[24];
        dec.set_flags = instr[20];
        dec.imm       = instr[25];
        dec.load      = instr[20];
        dec.link      = instr[27];
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle processor control FSM (Moore). Sequences fetch, decode and
// execution of data-processing, load/store and branch instructions by
// driving the datapath write enables, mux selects and memory strobes.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   instr, condition         - IR contents and condition-pass flag
//   ALU_control              - ALU operation
//   PC_Write/IR_Write/regwrite, ld_V/N/Z/C - write/load enables
//   I_or_D ... wr_sel        - datapath mux selects
//   mem_read, mem_write      - memory strobes
//   state                    - current state (debug)
//
// state     | meaning
// ----------+--------------------------------------------------
// FETCH     | read IR from memory at PC, PC <= PC+1
// DECODE    | read registers, check condition, dispatch on type
// DP_EXEC   | ALU operation, optional flag load
// DP_WB     | write ALU result to destination register
// MEM_ADDR  | compute effective address base + offset
// MEM_RD    | read memory into MDR
// MEM_WB    | write MDR to destination register
// MEM_WR    | write store data to memory
// BRANCH    | PC <= PC+1+offset, optional link to R15
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        condition,
    output logic [2:0]  ALU_control,
    output logic        PC_Write,
    output logic        IR_Write,
    output logic        regwrite,
    output logic        ld_V,
    output logic        ld_N,
    output logic        ld_Z,
    output logic        ld_C,
    output logic        I_or_D,
    output logic        WD_sel,
    output logic        MDR_sel,
    output logic        OP_sel,
    output logic        OP2_sel,
    output logic        MUX_sel,
    output logic        Pc_set,
    output logic        Data_sel,
    output logic        rr_sel,
    output logic        wr_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  state
);

    dec_t       dec;
    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl_d;
    ctrl_t      ctrl;

    mc_controller_instr_decode u_instr_decode (
        .instr (instr),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_FETCH;
        unique case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (!condition || dec.itype == TYPE_RSV) begin
                    state_d = ST_FETCH;
                end else if (dec.itype == TYPE_DP) begin
                    state_d = ST_DP_EXEC;
                end else if (dec.itype == TYPE_MEM) begin
                    state_d = ST_MEM_ADDR;
                end else begin
                    state_d = ST_BRANCH;
                end
            end
            ST_DP_EXEC:  state_d = dec.cmp_only ? ST_FETCH : ST_DP_WB;
            ST_DP_WB:    state_d = ST_FETCH;
            ST_MEM_ADDR: state_d = dec.load ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = ST_MEM_WB;
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_MEM_WR:   state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Moore outputs; ALU_control defaults to ADD, every other signal to 0.
    always_comb begin
        ctrl_d             = '0;
        ctrl_d.alu_control = ALU_ADD;
        unique case (state_q)
            ST_FETCH: begin
                ctrl_d.i_or_d   = 1'b0;
                ctrl_d.ir_write = 1'b1;
                ctrl_d.op_sel   = 1'b1;
                ctrl_d.data_sel = 1'b1;
                ctrl_d.pc_write = 1'b1;
                ctrl_d.mem_read = 1'b1;
            end
            ST_DECODE: begin
                ctrl_d.rr_sel = is_store(dec);
            end
            ST_DP_EXEC: begin
                ctrl_d.op2_sel     = dec.imm;
                ctrl_d.alu_control = dec.opcode;
                ctrl_d.ld_v        = writes_flags(dec);
                ctrl_d.ld_n        = writes_flags(dec);
                ctrl_d.ld_z        = writes_flags(dec);
                ctrl_d.ld_c        = writes_flags(dec);
            end
            ST_DP_WB: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.mdr_sel  = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl_d.op2_sel = 1'b1;
                ctrl_d.rr_sel  = is_store(dec);
            end
            ST_MEM_RD: begin
                ctrl_d.i_or_d   = 1'b1;
                ctrl_d.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_d.regwrite = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_d.i_or_d    = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.rr_sel    = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_d.op_sel   = 1'b1;
                ctrl_d.pc_set   = 1'b1;
                ctrl_d.data_sel = 1'b1;
                ctrl_d.pc_write = 1'b1;
                ctrl_d.regwrite = dec.link;
                ctrl_d.wr_sel   = dec.link;
                ctrl_d.wd_sel   = dec.link;
            end
            default: ctrl_d = '0;
        endcase
    end

    // The state register resets to FETCH, whose outputs are active; gating
    // with rst keeps every strobe low for as long as reset is held.
    always_comb begin
        ctrl = rst ? ctrl_d : '0;
    end

    assign state       = state_q;
    assign ALU_control = ctrl.alu_control;
    assign PC_Write    = ctrl.pc_write;
    assign IR_Write    = ctrl.ir_write;
    assign regwrite    = ctrl.regwrite;
    assign ld_V        = ctrl.ld_v;
    assign ld_N        = ctrl.ld_n;
    assign ld_Z        = ctrl.ld_z;
    assign ld_C        = ctrl.ld_c;
    assign I_or_D      = ctrl.i_or_d;
    assign WD_sel      = ctrl.wd_sel;
    assign MDR_sel     = ctrl.mdr_sel;
    assign OP_sel      = ctrl.op_sel;
    assign OP2_sel     = ctrl.op2_sel;
    assign MUX_sel     = ctrl.mux_sel;
    assign Pc_set      = ctrl.pc_set;
    assign Data_sel    = ctrl.data_sel;
    assign rr_sel      = ctrl.rr_sel;
    assign wr_sel      = ctrl.wr_sel;
    assign mem_read    = ctrl.mem_read;
    assign mem_write   = ctrl.mem_write;

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: walks each instruction class
// through the FSM and compares state and the full control bundle per cycle.
module tb_mc_controller;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        condition;
    logic [2:0]  ALU_control;
    logic        PC_Write, IR_Write, regwrite;
    logic        ld_V, ld_N, ld_Z, ld_C;
    logic        I_or_D, WD_sel, MDR_sel, OP_sel, OP2_sel, MUX_sel;
    logic        Pc_set, Data_sel, rr_sel, wr_sel;
    logic        mem_read, mem_write;
    logic [3:0]  state;

    int checks   = 0;
    int failures = 0;

    mc_controller dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .condition   (condition),
        .ALU_control (ALU_control),
        .PC_Write    (PC_Write),
        .IR_Write    (IR_Write),
        .regwrite    (regwrite),
        .ld_V        (ld_V),
        .ld_N        (ld_N),
        .ld_Z        (ld_Z),
        .ld_C        (ld_C),
        .I_or_D      (I_or_D),
        .WD_sel      (WD_sel),
        .MDR_sel     (MDR_sel),
        .OP_sel      (OP_sel),
        .OP2_sel     (OP2_sel),
        .MUX_sel     (MUX_sel),
        .Pc_set      (Pc_set),
        .Data_sel    (Data_sel),
        .rr_sel      (rr_sel),
        .wr_sel      (wr_sel),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle bit layout: [21:19] ALU, then one bit per strobe.
    logic [21:0] ctrl;
    assign ctrl = {ALU_control, PC_Write, IR_Write, regwrite, ld_V, ld_N, ld_Z, ld_C,
                   I_or_D, WD_sel, MDR_sel, OP_sel, OP2_sel, MUX_sel, Pc_set,
                   Data_sel, rr_sel, wr_sel, mem_read, mem_write};

    localparam logic [21:0] M_PCW  = 22'd1 << 18;
    localparam logic [21:0] M_IRW  = 22'd1 << 17;
    localparam logic [21:0] M_RW   = 22'd1 << 16;
    localparam logic [21:0] M_LD   = 22'hF << 12;
    localparam logic [21:0] M_IORD = 22'd1 << 11;
    localparam logic [21:0] M_WD   = 22'd1 << 10;
    localparam logic [21:0] M_MDR  = 22'd1 << 9;
    localparam logic [21:0] M_OP   = 22'd1 << 8;
    localparam logic [21:0] M_OP2  = 22'd1 << 7;
    localparam logic [21:0] M_PCS  = 22'd1 << 5;
    localparam logic [21:0] M_DAT  = 22'd1 << 4;
    localparam logic [21:0] M_RR   = 22'd1 << 3;
    localparam logic [21:0] M_WR   = 22'd1 << 2;
    localparam logic [21:0] M_MR   = 22'd1 << 1;
    localparam logic [21:0] M_MW   = 22'd1 << 0;

    localparam logic [21:0] C_NONE  = 22'd0;
    localparam logic [21:0] C_FETCH = M_IRW | M_OP | M_DAT | M_PCW | M_MR;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_DP_EXEC = 4'd2,
                           S_DP_WB = 4'd3, S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5,
                           S_MEM_WB = 4'd6, S_MEM_WR = 4'd7, S_BRANCH = 4'd8;

    function automatic logic [21:0] alu(input logic [2:0] op);
        return {op, 19'd0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_state, input logic [21:0] exp_ctrl);
        checks++;
        assert (state === exp_state) else begin
            failures++;
            $error("FAIL %s state got=%0d exp=%0d", tag, state, exp_state);
        end
        checks++;
        assert (ctrl === exp_ctrl) else begin
            failures++;
            $error("FAIL %s ctrl got=%06h exp=%06h", tag, ctrl, exp_ctrl);
        end
    endtask

    initial begin
        rst       = 1'b0;
        instr     = 32'hFFFF_FFFF;
        condition = 1'b1;
        repeat (3) cyc();
        chk("reset_hold", S_FETCH, C_NONE);

        // ADD S=1 register operand
        instr = 32'h0012_3003;
        rst   = 1'b1;
        #1;
        chk("release_fetch", S_FETCH, C_FETCH);
        cyc(); chk("add_decode", S_DECODE, C_NONE);
        cyc(); chk("add_exec",   S_DP_EXEC, alu(3'b000) | M_LD);
        cyc(); chk("add_wb",     S_DP_WB, M_RW | M_MDR);
        cyc(); chk("add_fetch",  S_FETCH, C_FETCH);

        // CMP immediate: no write-back
        instr = 32'h03E0_0001;
        cyc(); chk("cmp_decode", S_DECODE, C_NONE);
        cyc(); chk("cmp_exec",   S_DP_EXEC, alu(3'b111) | M_OP2 | M_LD);
        cyc(); chk("cmp_fetch",  S_FETCH, C_FETCH);

        // SUB S=0: no flag load
        instr = 32'h0020_0000;
        cyc(); chk("sub_decode", S_DECODE, C_NONE);
        cyc(); chk("sub_exec",   S_DP_EXEC, alu(3'b001));
        cyc(); chk("sub_wb",     S_DP_WB, M_RW | M_MDR);
        cyc(); chk("sub_fetch",  S_FETCH, C_FETCH);

        // LDR
        instr = 32'h1010_0004;
        cyc(); chk("ldr_decode", S_DECODE, C_NONE);
        cyc(); chk("ldr_addr",   S_MEM_ADDR, M_OP2);
        cyc(); chk("ldr_rd",     S_MEM_RD, M_IORD | M_MR);
        cyc(); chk("ldr_wb",     S_MEM_WB, M_RW);
        cyc(); chk("ldr_fetch",  S_FETCH, C_FETCH);

        // STR
        instr = 32'h1000_0008;
        cyc(); chk("str_decode", S_DECODE, M_RR);
        cyc(); chk("str_addr",   S_MEM_ADDR, M_OP2 | M_RR);
        cyc(); chk("str_wr",     S_MEM_WR, M_IORD | M_MW | M_RR);
        cyc(); chk("str_fetch",  S_FETCH, C_FETCH);

        // BL taken
        instr = 32'h2800_0010;
        cyc(); chk("bl_decode", S_DECODE, C_NONE);
        cyc(); chk("bl_branch", S_BRANCH, M_OP | M_PCS | M_DAT | M_PCW | M_RW | M_WR | M_WD);
        cyc(); chk("bl_fetch",  S_FETCH, C_FETCH);

        // B without link
        instr = 32'h2000_0005;
        cyc(); chk("b_decode", S_DECODE, C_NONE);
        cyc(); chk("b_branch", S_BRANCH, M_OP | M_PCS | M_DAT | M_PCW);
        cyc(); chk("b_fetch",  S_FETCH, C_FETCH);

        // BL with condition fail: skipped
        instr     = 32'h2800_0010;
        condition = 1'b0;
        cyc(); chk("blskip_decode", S_DECODE, C_NONE);
        cyc(); chk("blskip_fetch",  S_FETCH, C_FETCH);

        // STR with condition fail still shows rr_sel in DECODE then skips
        instr = 32'h1000_0000;
        cyc(); chk("strskip_decode", S_DECODE, M_RR);
        cyc(); chk("strskip_fetch",  S_FETCH, C_FETCH);

        // Reserved type with condition pass
        instr     = 32'h3000_0000;
        condition = 1'b1;
        cyc(); chk("rsv_decode", S_DECODE, C_NONE);
        cyc(); chk("rsv_fetch",  S_FETCH, C_FETCH);

        // LDR abandoned by reset during MEM_RD
        instr = 32'h1010_0000;
        cyc(); chk("abort_decode", S_DECODE, C_NONE);
        cyc(); chk("abort_addr",   S_MEM_ADDR, M_OP2);
        cyc(); chk("abort_rd",     S_MEM_RD, M_IORD | M_MR);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_async", S_FETCH, C_NONE);
        cyc(); chk("abort_hold", S_FETCH, C_NONE);
        rst = 1'b1;
        #1;
        chk("abort_release", S_FETCH, C_FETCH);
        cyc(); chk("abort_redecode", S_DECODE, C_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
